// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter: FSM state encoding, operation
// type and the default data width.
package stack_pkg;

   localparam int unsigned DATA_W_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE,
      OP,
      SETTLE
   } state_e;

   typedef enum logic {
      PUSH,
      POP
   } op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker with lock override.
//   elig_i       : per-requester eligibility
//   ptr_i        : preferred requester
//   lock_vld_i   : last owner exists and holds its lock request
//   lock_owner_i : index of the last owner
//   winner_o     : selected requester (valid when gnt_vld_o)
//   gnt_vld_o    : at least one requester is eligible
//   locked_o     : selection came from the lock (pointer must not move)
module rr_arb2 (
   input  logic [1:0] elig_i,
   input  logic       ptr_i,
   input  logic       lock_vld_i,
   input  logic       lock_owner_i,
   output logic       winner_o,
   output logic       gnt_vld_o,
   output logic       locked_o
);

   always_comb begin
      gnt_vld_o = |elig_i;
      // An ineligible lock owner forfeits the lock for this cycle only.
      locked_o  = lock_vld_i && elig_i[lock_owner_i];
      if (locked_o) begin
         winner_o = lock_owner_i;
      end else if (elig_i[ptr_i]) begin
         winner_o = ptr_i;
      end else begin
         winner_o = ~ptr_i;
      end
   end

endmodule

// File: rtl/stack_arb.sv
// Arbitrates two requesters onto a single stack port. One operation is
// issued per IDLE->OP->SETTLE round; SETTLE lets the stack flags catch up
// before the next arbitration.
//   CLK, RST      : clock, synchronous active-high reset
//   REQ_PUSH/POP  : per-requester level requests, held until GNT
//   REQ_DATA      : per-requester push data (slice i = requester i)
//   REQ_LOCK      : owner keeps the stack across consecutive operations
//   GNT           : one-cycle pulse in OP for the winner
//   RSP_VALID     : one-cycle pulse in SETTLE for a pop result
//   RSP_DATA      : pop result, held between responses
//   STK_PUSH/POP  : one-cycle stack strobes in OP
//   STK_DATA_IN   : captured data during OP, 0 otherwise
//   STK_DATA_OUT  : top of stack, STK_FULL/STK_EMPTY : stack flags
module stack_arb
   import stack_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned N_REQ  = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [N_REQ-1:0]        REQ_PUSH,
   input  logic [N_REQ-1:0]        REQ_POP,
   input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
   input  logic [N_REQ-1:0]        REQ_LOCK,
   output logic [N_REQ-1:0]        GNT,
   output logic [N_REQ-1:0]        RSP_VALID,
   output logic [DATA_W-1:0]       RSP_DATA,
   output logic                    STK_PUSH,
   output logic                    STK_POP,
   output logic [DATA_W-1:0]       STK_DATA_IN,
   input  logic [DATA_W-1:0]       STK_DATA_OUT,
   input  logic                    STK_FULL,
   input  logic                    STK_EMPTY
);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic                ptr_q, ptr_d;
   logic                owner_q, owner_d;
   logic                owner_vld_q, owner_vld_d;
   logic                winner_q, winner_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                stk_push_q, stk_push_d;
   logic                stk_pop_q, stk_pop_d;
   logic [DATA_W-1:0]   stk_din_q, stk_din_d;

   logic [1:0]          elig;
   logic                arb_win;
   logic                arb_vld;
   logic                arb_locked;
   logic [DATA_W-1:0]   data_sel;

   always_comb begin
      elig[0] = (REQ_PUSH[0] && !STK_FULL) || (REQ_POP[0] && !STK_EMPTY);
      elig[1] = (REQ_PUSH[1] && !STK_FULL) || (REQ_POP[1] && !STK_EMPTY);
   end

   assign data_sel = arb_win ? REQ_DATA[2*DATA_W-1:DATA_W] : REQ_DATA[DATA_W-1:0];

   rr_arb2 u_arb (
      .elig_i       (elig),
      .ptr_i        (ptr_q),
      .lock_vld_i   (owner_vld_q && REQ_LOCK[owner_q]),
      .lock_owner_i (owner_q),
      .winner_o     (arb_win),
      .gnt_vld_o    (arb_vld),
      .locked_o     (arb_locked)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      winner_d    = winner_q;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      stk_push_d  = 1'b0;
      stk_pop_d   = 1'b0;
      stk_din_d   = '0;

      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               state_d     = OP;
               winner_d    = arb_win;
               owner_d     = arb_win;
               owner_vld_d = 1'b1;
               if (!arb_locked) begin
                  ptr_d = ~arb_win;
               end
               // Push wins over a simultaneous pop when both are serviceable.
               op_d            = (REQ_PUSH[arb_win] && !STK_FULL) ? PUSH : POP;
               gnt_d[arb_win]  = 1'b1;
               stk_push_d      = (op_d == PUSH);
               stk_pop_d       = (op_d == POP);
               stk_din_d       = data_sel;
            end
         end
         OP: begin
            state_d = SETTLE;
            if (op_q == POP) begin
               rsp_valid_d[winner_q] = 1'b1;
               rsp_data_d            = STK_DATA_OUT;
            end
         end
         SETTLE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         op_q        <= PUSH;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         owner_vld_q <= 1'b0;
         winner_q    <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         stk_push_q  <= 1'b0;
         stk_pop_q   <= 1'b0;
         stk_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         winner_q    <= winner_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         stk_push_q  <= stk_push_d;
         stk_pop_q   <= stk_pop_d;
         stk_din_q   <= stk_din_d;
      end
   end

   assign GNT         = gnt_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_DATA    = rsp_data_q;
   assign STK_PUSH    = stk_push_q;
   assign STK_POP     = stk_pop_q;
   assign STK_DATA_IN = stk_din_q;

endmodule

// File: tb/tb_stack_arb.sv
// Scoreboard bench for stack_arb: directed stimulus pushes hand-computed
// expected grants/responses; a negedge monitor pops and compares them.
module tb_stack_arb;

   logic       clk;
   logic       rst;
   logic [1:0] req_push;
   logic [1:0] req_pop;
   logic [3:0] req_data;
   logic [1:0] req_lock;
   logic [1:0] gnt;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_data;
   logic       stk_push;
   logic       stk_pop;
   logic [1:0] stk_din;
   logic [1:0] stk_dout;
   logic       stk_full;
   logic       stk_empty;

   typedef struct {
      logic [1:0] gnt;
      logic       push;
      logic       pop;
      logic [1:0] din;
      int         gap;
   } gexp_t;

   typedef struct {
      logic [1:0] v;
      logic [1:0] d;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int last_g = 0;

   stack_arb #(.DATA_W(2), .N_REQ(2)) dut (
      .CLK          (clk),
      .RST          (rst),
      .REQ_PUSH     (req_push),
      .REQ_POP      (req_pop),
      .REQ_DATA     (req_data),
      .REQ_LOCK     (req_lock),
      .GNT          (gnt),
      .RSP_VALID    (rsp_valid),
      .RSP_DATA     (rsp_data),
      .STK_PUSH     (stk_push),
      .STK_POP      (stk_pop),
      .STK_DATA_IN  (stk_din),
      .STK_DATA_OUT (stk_dout),
      .STK_FULL     (stk_full),
      .STK_EMPTY    (stk_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic exp_g(input logic [1:0] g, input logic pu, input logic po,
                        input logic [1:0] d, input int gap);
      gexp_t e;
      e.gnt = g; e.push = pu; e.pop = po; e.din = d; e.gap = gap;
      gq.push_back(e);
   endtask

   task automatic exp_r(input logic [1:0] v, input logic [1:0] d);
      rexp_t e;
      e.v = v; e.d = d;
      rq.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      if ((|gnt) || stk_push || stk_pop) begin
         if (gq.size() == 0) begin
            chk("unexpected_grant", {27'd0, gnt, stk_push, stk_pop, stk_din}, 32'd0);
         end else begin
            gexp_t e;
            e = gq.pop_front();
            chk("grant", {27'd0, gnt, stk_push, stk_pop, stk_din},
                {27'd0, e.gnt, e.push, e.pop, e.din});
            if (e.gap != 0) chk("grant_gap", cyc_n - last_g, e.gap);
            last_g = cyc_n;
         end
      end else begin
         chk("din_idle", {30'd0, stk_din}, 32'd0);
      end
      if (|rsp_valid) begin
         if (rq.size() == 0) begin
            chk("unexpected_rsp", {28'd0, rsp_valid, rsp_data}, 32'd0);
         end else begin
            rexp_t r;
            r = rq.pop_front();
            chk("rsp", {28'd0, rsp_valid, rsp_data}, {28'd0, r.v, r.d});
         end
      end
   end

   initial begin
      rst = 1'b1; req_push = 2'b11; req_pop = 2'b00; req_lock = 2'b00;
      req_data = {2'b10, 2'b01}; stk_full = 1'b0; stk_empty = 1'b1; stk_dout = 2'b00;

      // Reset, then contention: alternating grants, first to requester 0
      cyc(2);
      chk("reset_outputs", {22'd0, gnt, rsp_valid, rsp_data, stk_push, stk_pop, stk_din}, 32'd0);
      exp_g(2'b01, 1, 0, 2'b01, 0);
      exp_g(2'b10, 1, 0, 2'b10, 3);
      exp_g(2'b01, 1, 0, 2'b01, 3);
      exp_g(2'b10, 1, 0, 2'b10, 3);
      rst = 1'b0;
      cyc(10);
      req_push = 2'b00;
      cyc(3);

      // Single push into empty stack
      req_data = {2'b10, 2'b10};
      exp_g(2'b01, 1, 0, 2'b10, 0);
      req_push = 2'b01;
      cyc(1);
      req_push = 2'b00;
      cyc(3);

      // Pop by requester 1, top = 11; RSP_DATA then holds
      stk_empty = 1'b0; stk_dout = 2'b11;
      exp_g(2'b10, 0, 1, 2'b10, 0);
      exp_r(2'b10, 2'b11);
      req_pop = 2'b10;
      cyc(1);
      req_pop = 2'b00;
      cyc(2);
      stk_dout = 2'b00;
      cyc(2);
      chk("rsp_hold", {29'd0, rsp_valid, rsp_data[0]}, 32'd1);
      chk("rsp_hold_data", {30'd0, rsp_data}, 32'd3);

      // Lock by requester 0: 0,0,0 then 1 after lock drops
      req_data = {2'b01, 2'b11};
      exp_g(2'b01, 1, 0, 2'b11, 0);
      exp_g(2'b01, 1, 0, 2'b11, 3);
      exp_g(2'b01, 1, 0, 2'b11, 3);
      exp_g(2'b10, 1, 0, 2'b01, 3);
      req_push = 2'b11; req_lock = 2'b01;
      cyc(7);
      req_lock = 2'b00;
      cyc(3);
      req_push = 2'b00;
      cyc(3);

      // Full/empty blocking
      stk_full = 1'b1; stk_empty = 1'b1;
      req_push = 2'b01; req_pop = 2'b10;
      cyc(6);
      chk("blocked", {28'd0, gnt, stk_push, stk_pop}, 32'd0);
      exp_g(2'b01, 1, 0, 2'b11, 0);
      stk_full = 1'b0;
      cyc(1);
      req_push = 2'b00;
      cyc(2);
      exp_g(2'b10, 0, 1, 2'b01, 3);
      exp_r(2'b10, 2'b01);
      stk_empty = 1'b0; stk_dout = 2'b01;
      cyc(1);
      req_pop = 2'b00;
      cyc(3);

      // Simultaneous push and pop from requester 0: push first
      req_data = {2'b01, 2'b10}; stk_dout = 2'b10;
      exp_g(2'b01, 1, 0, 2'b10, 0);
      exp_g(2'b01, 0, 1, 2'b10, 3);
      exp_r(2'b01, 2'b10);
      req_push = 2'b01; req_pop = 2'b01;
      cyc(1);
      req_push = 2'b00;
      cyc(3);
      req_pop = 2'b00;
      cyc(3);

      // Reset during OP: no response, IDLE immediately afterwards
      stk_dout = 2'b01;
      exp_g(2'b10, 0, 1, 2'b01, 0);
      req_pop = 2'b10;
      cyc(1);
      rst = 1'b1; req_pop = 2'b00;
      cyc(1);
      chk("abort_outputs", {26'd0, gnt, stk_push, stk_pop, rsp_valid}, 32'd0);
      exp_g(2'b01, 1, 0, 2'b10, 2);
      rst = 1'b0; req_push = 2'b01;
      cyc(1);
      req_push = 2'b00;
      cyc(4);

      chk("grants_pending", gq.size(), 32'd0);
      chk("rsps_pending", rq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
